// File: rtl/alu_pkg.sv
// Shared ALU types: the operation encoding used by the ALU and every arbiter
// that feeds it, plus the branch-compare encoding used by the branch unit.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_cmd_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd2,
        BR_GE  = 3'd3,
        BR_LTU = 3'd4,
        BR_GEU = 3'd5
    } branch_alu_cmd_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU; shifts use only rhs_i[4:0].
module alu
    import alu_pkg::*;
(
    input  alu_cmd_t          cmd_i,
    input  logic [ALU_W-1:0]  lhs_i,
    input  logic [ALU_W-1:0]  rhs_i,
    output logic [ALU_W-1:0]  res_o
);

    logic [4:0] shamt;

    assign shamt = rhs_i[4:0];

    always_comb begin
        res_o = '0;
        case (cmd_i)
            ALU_ADD: res_o = lhs_i + rhs_i;
            ALU_SUB: res_o = lhs_i - rhs_i;
            ALU_AND: res_o = lhs_i & rhs_i;
            ALU_OR:  res_o = lhs_i | rhs_i;
            ALU_XOR: res_o = lhs_i ^ rhs_i;
            ALU_SLL: res_o = lhs_i << shamt;
            ALU_SRL: res_o = lhs_i >> shamt;
            ALU_SRA: res_o = $unsigned($signed(lhs_i) >>> shamt);
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: the first set request at or after
// start_ptr (wrapping modulo NUM_REQ, which need not be a power of two) wins.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   start_ptr,
    output logic               gnt_valid,
    output logic [PTR_W-1:0]   gnt_idx
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, start_ptr} + (PTR_W + 1)'(off);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with a single registered result stage.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise lowest index wins.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic     [NUM_REQ-1:0]         req_valid_i,
    output logic     [NUM_REQ-1:0]         req_ready_o,
    input  alu_cmd_t [NUM_REQ-1:0]         req_cmd_i,
    input  logic     [NUM_REQ-1:0][31:0]   req_lhs_i,
    input  logic     [NUM_REQ-1:0][31:0]   req_rhs_i,
    output logic     [NUM_REQ-1:0]         rsp_valid_o,
    input  logic     [NUM_REQ-1:0]         rsp_ready_i,
    output logic     [31:0]                rsp_res_o,
    output logic                           busy_o
);

    logic             out_valid_q, out_valid_d;
    logic [PTR_W-1:0] out_owner_q, out_owner_d;
    logic [31:0]      out_res_q,   out_res_d;

    logic             gnt_valid;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] start_ptr;
    logic             stage_free;
    logic             accept;
    logic [31:0]      alu_res;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    assign start_ptr = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign start_ptr = '0;
`endif

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .PTR_W     (PTR_W)
    ) u_picker (
        .req       (req_valid_i),
        .start_ptr (start_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    alu u_alu (
        .cmd_i (req_cmd_i[gnt_idx]),
        .lhs_i (req_lhs_i[gnt_idx]),
        .rhs_i (req_rhs_i[gnt_idx]),
        .res_o (alu_res)
    );

    // A draining stage can accept in the same cycle, so there is no bubble.
    assign stage_free = !out_valid_q || rsp_ready_i[out_owner_q];
    assign accept     = gnt_valid && stage_free;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_owner_d = out_owner_q;
        out_res_d   = out_res_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_owner_d = gnt_idx;
            out_res_d   = alu_res;
        end else if (stage_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_owner_q <= '0;
            out_res_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_owner_q <= out_owner_d;
            out_res_q   <= out_res_d;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_o[i] = out_valid_q && (out_owner_q == PTR_W'(i));
        end
    end

    assign rsp_res_o = out_res_q;
    assign busy_o    = out_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester and a 3-requester instance,
// with expectations for both the fixed-priority and round-robin builds.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic     [1:0]       valid2, ready2, rspv2, rspr2;
    alu_cmd_t [1:0]       cmd2;
    logic     [1:0][31:0] lhs2, rhs2;
    logic     [31:0]      res2;
    logic                 busy2;

    logic     [2:0]       valid3, ready3, rspv3, rspr3;
    alu_cmd_t [2:0]       cmd3;
    logic     [2:0][31:0] lhs3, rhs3;
    logic     [31:0]      res3;
    logic                 busy3;

    alu_arbiter #(.NUM_REQ(2)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (valid2),
        .req_ready_o (ready2),
        .req_cmd_i   (cmd2),
        .req_lhs_i   (lhs2),
        .req_rhs_i   (rhs2),
        .rsp_valid_o (rspv2),
        .rsp_ready_i (rspr2),
        .rsp_res_o   (res2),
        .busy_o      (busy2)
    );

    alu_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (valid3),
        .req_ready_o (ready3),
        .req_cmd_i   (cmd3),
        .req_lhs_i   (lhs3),
        .req_rhs_i   (rhs3),
        .rsp_valid_o (rspv3),
        .rsp_ready_i (rspr3),
        .rsp_res_o   (res3),
        .busy_o      (busy3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    logic [1:0]  exp_g2;
    logic [31:0] exp_r2;
    logic [2:0]  exp_g3;
    logic [31:0] exp_r3;

    initial begin
        rst_n  = 1'b0;
        valid2 = '0; rspr2 = '0; lhs2 = '0; rhs2 = '0;
        cmd2[0] = ALU_ADD; cmd2[1] = ALU_ADD;
        valid3 = '0; rspr3 = 3'b111; lhs3 = '0; rhs3 = '0;
        cmd3[0] = ALU_ADD; cmd3[1] = ALU_ADD; cmd3[2] = ALU_ADD;

        @(negedge clk);
        check("rst_ready", 32'(ready2), 32'h0);
        check("rst_rspv",  32'(rspv2),  32'h0);
        check("rst_res",   res2,        32'h0);
        check("rst_busy",  32'(busy2),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: 5 + 7
        valid2 = 2'b01; cmd2[0] = ALU_ADD; lhs2[0] = 32'd5; rhs2[0] = 32'd7; rspr2 = 2'b11;
        #1 check("t1_ready", 32'(ready2), 32'h1);
        @(negedge clk);
        check("t1_rspv", 32'(rspv2), 32'h1);
        check("t1_res",  res2,       32'd12);
        check("t1_busy", 32'(busy2), 32'h1);
        valid2 = 2'b00;
        #1 check("t1_idle_ready", 32'(ready2), 32'h0);
        @(negedge clk);
        check("t1_drain_busy", 32'(busy2), 32'h0);
        check("t1_drain_rspv", 32'(rspv2), 32'h0);
        check("t1_res_hold",   res2,       32'd12);

        // Contention: Sub 10-3 on req0, Xor F0^0F on req1
        valid2 = 2'b11;
        cmd2[0] = ALU_SUB; lhs2[0] = 32'd10;   rhs2[0] = 32'd3;
        cmd2[1] = ALU_XOR; lhs2[1] = 32'hF0;   rhs2[1] = 32'h0F;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_g2 = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_r2 = (k % 2 == 0) ? 32'hFF : 32'd7;
`else
            exp_g2 = 2'b01;
            exp_r2 = 32'd7;
`endif
            #1 check($sformatf("t2_ready_%0d", k), 32'(ready2), 32'(exp_g2));
            @(negedge clk);
            check($sformatf("t2_rspv_%0d", k), 32'(rspv2), 32'(exp_g2));
            check($sformatf("t2_res_%0d", k),  res2,       exp_r2);
        end

        // Backpressure: req1 Sra stalled for 3 cycles while req0 waits
        valid2 = 2'b10; rspr2 = 2'b01;
        cmd2[1] = ALU_SRA; lhs2[1] = 32'h8000_0000; rhs2[1] = 32'd4;
        #1 check("t3_ready", 32'(ready2), 32'h2);
        @(negedge clk);
        check("t3_rspv", 32'(rspv2), 32'h2);
        check("t3_res",  res2,       32'hF800_0000);
        valid2 = 2'b01; cmd2[0] = ALU_ADD; lhs2[0] = 32'd5; rhs2[0] = 32'd7;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("t3_stall_ready_%0d", k), 32'(ready2), 32'h0);
            check($sformatf("t3_stall_rspv_%0d", k), 32'(rspv2), 32'h2);
            check($sformatf("t3_stall_res_%0d", k),  res2,       32'hF800_0000);
            @(negedge clk);
        end
        rspr2 = 2'b11;
        #1 check("t3_release_ready", 32'(ready2), 32'h1);
        @(negedge clk);
        check("t3_next_rspv", 32'(rspv2), 32'h1);
        check("t3_next_res",  res2,       32'd12);
        valid2 = 2'b00;
        @(negedge clk);

        // Reset while req1's result is stalled
        valid2 = 2'b10; cmd2[1] = ALU_ADD; lhs2[1] = 32'd1; rhs2[1] = 32'd2; rspr2 = 2'b00;
        #1 check("t4_ready", 32'(ready2), 32'h2);
        @(negedge clk);
        check("t4_stall_rspv", 32'(rspv2), 32'h2);
        check("t4_stall_res",  res2,       32'd3);
        valid2 = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_rspv",  32'(rspv2),  32'h0);
        check("t4_async_res",   res2,        32'h0);
        check("t4_async_busy",  32'(busy2),  32'h0);
        check("t4_async_ready", 32'(ready2), 32'h0);
        rspr2 = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_post_rspv", 32'(rspv2), 32'h0);
        check("t4_post_busy", 32'(busy2), 32'h0);
        valid2 = 2'b11;
        cmd2[0] = ALU_ADD; lhs2[0] = 32'd5; rhs2[0] = 32'd7;
        #1 check("t4_restart_ready", 32'(ready2), 32'h1);
        @(negedge clk);
        check("t4_restart_rspv", 32'(rspv2), 32'h1);
        check("t4_restart_res",  res2,       32'd12);
        valid2 = 2'b00;

        // Three requesters: wrap order, plus Sll using only rhs[4:0]
        valid3 = 3'b111;
        cmd3[0] = ALU_ADD; lhs3[0] = 32'd1;     rhs3[0] = 32'd1;
        cmd3[1] = ALU_SLL; lhs3[1] = 32'd1;     rhs3[1] = 32'h25;
        cmd3[2] = ALU_OR;  lhs3[2] = 32'h0F00;  rhs3[2] = 32'h00F0;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            case (k)
                1:       begin exp_g3 = 3'b010; exp_r3 = 32'h20;   end
                2:       begin exp_g3 = 3'b100; exp_r3 = 32'h0FF0; end
                default: begin exp_g3 = 3'b001; exp_r3 = 32'd2;    end
            endcase
`else
            exp_g3 = 3'b001;
            exp_r3 = 32'd2;
`endif
            #1 check($sformatf("t5_ready_%0d", k), 32'(ready3), 32'(exp_g3));
            @(negedge clk);
            check($sformatf("t5_rspv_%0d", k), 32'(rspv3), 32'(exp_g3));
            check($sformatf("t5_res_%0d", k),  res3,       exp_r3);
        end
        valid3 = 3'b010;
        #1 check("t5_sll_ready", 32'(ready3), 32'h2);
        @(negedge clk);
        check("t5_sll_rspv", 32'(rspv3), 32'h2);
        check("t5_sll_res",  res3,       32'h20);
        valid3 = 3'b000;
        @(negedge clk);
        check("t5_idle_busy", 32'(busy3), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
